// File: rtl/enc_reader_if.sv
// -----------------------------------------------------------------------------
// enc_reader_if
//
// Controller-side handshake of the ENC28J60 register read engine.
//
//   run_req    : start request, level-sampled while the reader is idle
//   opcode     : SPI opcode (000 = RCR), captured at accept
//   read_addr  : register address, captured at accept
//   dummy_byte : 1 = clock one dummy byte before data (MAC/MII registers)
//   read_data  : last received byte
//   read_valid : one-cycle pulse, read_data freshly updated
//   busy       : transaction in progress
//
// master = controller FSM side, slave = enc_reader side.
// -----------------------------------------------------------------------------
interface enc_reader_if;
  logic       run_req;
  logic [2:0] opcode;
  logic [4:0] read_addr;
  logic       dummy_byte;
  logic [7:0] read_data;
  logic       read_valid;
  logic       busy;

  modport master (
    output run_req, opcode, read_addr, dummy_byte,
    input  read_data, read_valid, busy
  );

  modport slave (
    input  run_req, opcode, read_addr, dummy_byte,
    output read_data, read_valid, busy
  );
endinterface

// File: rtl/enc_reader.sv
// -----------------------------------------------------------------------------
// enc_reader
//
// SPI mode-0 master that reads one register byte from an ENC28J60.
// Frame: SS low, command byte {opcode, read_addr}, optional dummy byte
// (MAC/MII registers), one data byte shifted in from MISO MSB first, SS high.
//
// Every SPI bit is split into four phases of PHASE_CYCLES clk cycles each:
//   A: SCLK=0, MOSI takes the new bit
//   B: SCLK=1            C: SCLK=1 (MISO sampled on the edge ending C)
//   D: SCLK=0
// START and STOP framing also use four phases so that SS has set-up and
// hold time around the first and last SCLK edge.
//
// Ports:
//   clk        : system clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   ctl        : controller handshake (enc_reader_if.slave)
//   SCLK       : SPI clock, idle low
//   MOSI       : SPI data out
//   MISO       : SPI data in
//   SS         : SPI chip select, active low
//
// All pin outputs are registered: the next-state logic decides which
// state/phase/bit the machine will be in after the edge, and the pin values
// for that slot are registered on the same edge.
// -----------------------------------------------------------------------------
module enc_reader #(
  parameter int PHASE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  enc_reader_if.slave  ctl,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO,
  output logic         SS
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_DUMMY,
    ST_RECV,
    ST_STOP
  } state_t;

  typedef enum logic [1:0] {
    PH_A,
    PH_B,
    PH_C,
    PH_D
  } phase_t;

  // Phase-length counter width; a 1-bit counter is kept even for
  // PHASE_CYCLES=1 so the code needs no special case.
  localparam int             PCW     = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PHASE_CYCLES - 1);

  // State registers
  state_t         r_state;
  phase_t         r_phase;
  logic [PCW-1:0] r_pcnt;
  logic [2:0]     r_bit;      // bit index within the current byte, 7..0

  // Transaction context captured at accept
  logic [7:0]     r_cmd;
  logic           r_dummy;

  // Datapath / output registers
  logic [7:0]     r_shift;
  logic [7:0]     r_read_data;
  logic           r_read_valid;
  logic           r_busy;
  logic           r_sclk;
  logic           r_mosi;
  logic           r_ss;

  // Next-state and decoded strobes
  state_t         w_nxt_state;
  phase_t         w_nxt_phase;
  logic [PCW-1:0] w_nxt_pcnt;
  logic [2:0]     w_nxt_bit;
  logic           w_accept;
  logic           w_phase_end;
  logic           w_sample;
  logic           w_done;

  // Pin values for the slot being entered
  logic           w_ss;
  logic           w_sclk;
  logic           w_mosi;

  // ---------------------------------------------------------------------------
  // Sequencing: state / phase / bit counters
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in combinational logic infers a latch.
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_pcnt  = r_pcnt;
    w_nxt_bit   = r_bit;

    w_accept    = (r_state == ST_IDLE) && ctl.run_req;
    w_phase_end = (r_pcnt == PC_LAST);
    // Only the data byte is kept; command and dummy bytes never load r_shift.
    w_sample    = (r_state == ST_RECV) && (r_phase == PH_C) && w_phase_end;
    w_done      = (r_state == ST_STOP) && (r_phase == PH_D) && w_phase_end;

    if (r_state == ST_IDLE) begin
      w_nxt_pcnt  = '0;
      w_nxt_phase = PH_A;
      w_nxt_bit   = 3'd7;
      if (ctl.run_req) begin
        w_nxt_state = ST_START;
      end
    end else if (!w_phase_end) begin
      w_nxt_pcnt = r_pcnt + 1'b1;
    end else begin
      w_nxt_pcnt  = '0;
      w_nxt_phase = phase_t'(r_phase + 2'd1);   // D wraps to A
      if (r_phase == PH_D) begin
        case (r_state)
          ST_START: w_nxt_state = ST_CMD;
          ST_CMD, ST_DUMMY, ST_RECV: begin
            // Decrement wraps 0 -> 7, which is the first bit of the next byte.
            w_nxt_bit = r_bit - 3'd1;
            if (r_bit == 3'd0) begin
              if (r_state == ST_CMD) begin
                w_nxt_state = r_dummy ? ST_DUMMY : ST_RECV;
              end else if (r_state == ST_DUMMY) begin
                w_nxt_state = ST_RECV;
              end else begin
                w_nxt_state = ST_STOP;
              end
            end
          end
          ST_STOP: w_nxt_state = ST_IDLE;
          default: w_nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pin values for the slot the machine enters on the next edge
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ss   = 1'b1;
    w_sclk = 1'b0;
    w_mosi = 1'b0;
    case (w_nxt_state)
      ST_START: begin
        // SS falls half-way through START: set-up time before the first SCLK.
        w_ss = (w_nxt_phase == PH_A) || (w_nxt_phase == PH_B);
      end
      ST_CMD: begin
        w_ss   = 1'b0;
        w_sclk = (w_nxt_phase == PH_B) || (w_nxt_phase == PH_C);
        // The bit index only moves at the D->A boundary, so MOSI is
        // constant across B, C and D of a bit.
        w_mosi = r_cmd[w_nxt_bit];
      end
      ST_DUMMY, ST_RECV: begin
        w_ss   = 1'b0;
        w_sclk = (w_nxt_phase == PH_B) || (w_nxt_phase == PH_C);
      end
      ST_STOP: begin
        // SS held low for two phases after the last SCLK fall (hold time).
        w_ss = (w_nxt_phase == PH_C) || (w_nxt_phase == PH_D);
      end
      default: begin
        w_ss = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the capture and shift registers are reset as well, so read_data
      // and the latched command are never X after reset.
      r_state      <= ST_IDLE;
      r_phase      <= PH_A;
      r_pcnt       <= '0;
      r_bit        <= 3'd7;
      r_cmd        <= '0;
      r_dummy      <= 1'b0;
      r_shift      <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_ss         <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      r_state      <= w_nxt_state;
      r_phase      <= w_nxt_phase;
      r_pcnt       <= w_nxt_pcnt;
      r_bit        <= w_nxt_bit;
      r_sclk       <= w_sclk;
      r_mosi       <= w_mosi;
      r_ss         <= w_ss;
      r_read_valid <= w_done;
      r_busy       <= (w_nxt_state != ST_IDLE);

      // Inputs are only looked at on the accept edge; later changes on the
      // controller side cannot disturb a running frame.
      if (w_accept) begin
        r_cmd   <= {ctl.opcode, ctl.read_addr};
        r_dummy <= ctl.dummy_byte;
      end

      if (w_sample) begin
        r_shift <= {r_shift[6:0], MISO};
      end

      if (w_done) begin
        r_read_data <= r_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SCLK           = r_sclk;
  assign MOSI           = r_mosi;
  assign SS             = r_ss;
  assign ctl.read_data  = r_read_data;
  assign ctl.read_valid = r_read_valid;
  assign ctl.busy       = r_busy;

endmodule

// File: tb/tb_enc_reader.sv
// -----------------------------------------------------------------------------
// tb_enc_reader
//
// Two readers: dut0 with PHASE_CYCLES=1 and dut1 with PHASE_CYCLES=3. Each has
// an ENC28J60-like SPI slave model that drives MISO from a 24-bit pattern
// (one byte per SPI byte slot, updated after every SCLK fall) and records
// MOSI on every SCLK rise, plus SCLK high/low widths and MOSI stability.
// -----------------------------------------------------------------------------
module tb_enc_reader;

  localparam int CLK_PER = 10;

  logic       clk;
  logic       rst;
  logic [1:0] sclk_v;
  logic [1:0] mosi_v;
  logic [1:0] miso_v;
  logic [1:0] ss_v;
  logic [23:0] miso_pat [2];
  logic [7:0]  prev_data [2];

  int n_tests = 0;
  int n_fail  = 0;

  enc_reader_if bus0 ();
  enc_reader_if bus1 ();

  enc_reader #(.PHASE_CYCLES(1)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .ctl  (bus0.slave),
    .SCLK (sclk_v[0]),
    .MOSI (mosi_v[0]),
    .MISO (miso_v[0]),
    .SS   (ss_v[0])
  );

  enc_reader #(.PHASE_CYCLES(3)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .ctl  (bus1.slave),
    .SCLK (sclk_v[1]),
    .MOSI (mosi_v[1]),
    .MISO (miso_v[1]),
    .SS   (ss_v[1])
  );

  initial clk = 1'b0;
  always #(CLK_PER / 2) clk = ~clk;

  // ---------------------------------------------------------------------------
  // SPI slave model / monitor, one per DUT
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam time EXP_T = 2 * ((g == 0) ? 1 : 3) * CLK_PER;
    int  rises    = 0;
    int  falls    = 0;
    int  rbase    = 0;
    int  fbase    = 0;
    int  ss_falls = 0;
    int  bad_hi   = 0;
    int  bad_lo   = 0;
    int  bad_mosi = 0;
    time t_rise   = 0;
    time t_fall   = 0;
    logic [23:0] mosi_sr = '0;
    int  idx;

    assign idx       = falls - fbase;
    assign miso_v[g] = (idx >= 0 && idx < 24) ? miso_pat[g][5'(23 - idx)] : 1'b0;

    always @(posedge sclk_v[g]) begin
      if (rises != rbase && ($time - t_fall) != EXP_T) bad_lo <= bad_lo + 1;
      rises   <= rises + 1;
      t_rise  <= $time;
      mosi_sr <= {mosi_sr[22:0], mosi_v[g]};
    end

    always @(negedge sclk_v[g]) begin
      if (($time - t_rise) != EXP_T) bad_hi <= bad_hi + 1;
      falls  <= falls + 1;
      t_fall <= $time;
    end

    always @(negedge ss_v[g]) begin
      rbase    <= rises;
      fbase    <= falls;
      ss_falls <= ss_falls + 1;
    end

    always @(mosi_v[g]) begin
      if (sclk_v[g]) bad_mosi <= bad_mosi + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Accessors
  // ---------------------------------------------------------------------------
  function automatic logic get_valid(input int g);
    return (g == 0) ? bus0.read_valid : bus1.read_valid;
  endfunction

  function automatic logic get_busy(input int g);
    return (g == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic [7:0] get_data(input int g);
    return (g == 0) ? bus0.read_data : bus1.read_data;
  endfunction

  function automatic int get_rises_txn(input int g);
    return (g == 0) ? (mon[0].rises - mon[0].rbase) : (mon[1].rises - mon[1].rbase);
  endfunction

  function automatic int get_rises_total(input int g);
    return (g == 0) ? mon[0].rises : mon[1].rises;
  endfunction

  function automatic int get_ss_falls(input int g);
    return (g == 0) ? mon[0].ss_falls : mon[1].ss_falls;
  endfunction

  function automatic int get_bad(input int g);
    return (g == 0) ? (mon[0].bad_hi + mon[0].bad_lo + mon[0].bad_mosi)
                    : (mon[1].bad_hi + mon[1].bad_lo + mon[1].bad_mosi);
  endfunction

  function automatic logic [23:0] get_mosi(input int g);
    return (g == 0) ? mon[0].mosi_sr : mon[1].mosi_sr;
  endfunction

  // ---------------------------------------------------------------------------
  // Tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int g, input logic rq, input logic [2:0] op,
                       input logic [4:0] a, input logic d);
    if (g == 0) begin
      bus0.run_req = rq; bus0.opcode = op; bus0.read_addr = a; bus0.dummy_byte = d;
    end else begin
      bus1.run_req = rq; bus1.opcode = op; bus1.read_addr = a; bus1.dummy_byte = d;
    end
  endtask

  task automatic drive_req(input int g, input logic rq);
    if (g == 0) bus0.run_req = rq;
    else        bus1.run_req = rq;
  endtask

  // Present a request, let the accept edge E0 take it, then scramble the
  // inputs; returns at E0 + 1 time unit.
  task automatic accept(input int g, input string tag, input logic [2:0] op,
                        input logic [4:0] a, input logic d);
    @(negedge clk);
    drive(g, 1'b1, op, a, d);
    @(posedge clk);
    #1;
    drive(g, 1'b0, ~op, ~a, ~d);
    check({tag, "_busy_after_accept"}, 32'(get_busy(g)), 32'd1);
    check({tag, "_data_held_at_start"}, 32'(get_data(g)), 32'(prev_data[g]));
  endtask

  // Counts edges after the current one until read_valid is seen; optionally
  // raises run_req at edges +10 and +40 (relative to E0) while busy.
  task automatic wait_valid(input int g, input bit pulse, output int lat);
    lat = -1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #1;
      drive_req(g, pulse && (n == 9 || n == 39));
      if (get_valid(g)) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    int          g;
    logic [2:0]  op;
    logic [4:0]  addr;
    logic        dummy;
    bit          pulse;
    logic [23:0] pat;
    logic [7:0]  exp_data;
    int          exp_lat;
    int          exp_rises;
    logic [7:0]  exp_cmd;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lat;
    int f0;
    int b0;
    logic [23:0] ms;
    miso_pat[v.g] = v.pat;
    f0 = get_ss_falls(v.g);
    b0 = get_bad(v.g);
    accept(v.g, v.name, v.op, v.addr, v.dummy);
    wait_valid(v.g, v.pulse, lat);
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_read_data"}, 32'(get_data(v.g)), 32'(v.exp_data));
    check({v.name, "_busy_low_at_valid"}, 32'(get_busy(v.g)), 32'd0);
    check({v.name, "_sclk_rises"}, 32'(get_rises_txn(v.g)), 32'(v.exp_rises));
    ms = get_mosi(v.g);
    if (v.dummy) check({v.name, "_mosi_bytes"}, {8'h00, ms}, {8'h00, v.exp_cmd, 16'h0000});
    else         check({v.name, "_mosi_bytes"}, {16'h0000, ms[15:0]}, {16'h0000, v.exp_cmd, 8'h00});
    @(posedge clk);
    #1;
    check({v.name, "_valid_one_cycle"}, 32'(get_valid(v.g)), 32'd0);
    check({v.name, "_data_holds"}, 32'(get_data(v.g)), 32'(v.exp_data));
    check({v.name, "_ss_idle_high"}, 32'(ss_v[v.g]), 32'd1);
    check({v.name, "_one_ss_frame"}, 32'(get_ss_falls(v.g) - f0), 32'd1);
    check({v.name, "_sclk_timing_mosi_stable"}, 32'(get_bad(v.g) - b0), 32'd0);
    prev_data[v.g] = v.exp_data;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t vecs [6];

  initial begin
    int lat;
    int r0;
    int v0;

    vecs[0] = '{"eth_1d",     0, 3'b000, 5'h1D, 1'b0, 1'b0, {8'h5A, 8'hA5, 8'h00}, 8'hA5,  72, 16, 8'h1D};
    vecs[1] = '{"mac_19_dum", 0, 3'b000, 5'h19, 1'b1, 1'b0, {8'h5A, 8'hFF, 8'h3C}, 8'h3C, 104, 24, 8'h19};
    vecs[2] = '{"op5_1f",     0, 3'b101, 5'h1F, 1'b0, 1'b0, {8'hFF, 8'h00, 8'hFF}, 8'h00,  72, 16, 8'hBF};
    vecs[3] = '{"op3_00_dum", 0, 3'b011, 5'h00, 1'b1, 1'b0, {8'h00, 8'h00, 8'h81}, 8'h81, 104, 24, 8'h60};
    vecs[4] = '{"busy_pulse", 0, 3'b000, 5'h0A, 1'b0, 1'b1, {8'hFF, 8'h7E, 8'h00}, 8'h7E,  72, 16, 8'h0A};
    vecs[5] = '{"pc3_eth_1d", 1, 3'b000, 5'h1D, 1'b0, 1'b0, {8'h5A, 8'hA5, 8'h00}, 8'hA5, 216, 16, 8'h1D};

    rst = 1'b0;
    drive(0, 1'b0, 3'b000, 5'h00, 1'b0);
    drive(1, 1'b0, 3'b000, 5'h00, 1'b0);
    miso_pat[0] = '0;
    miso_pat[1] = '0;
    prev_data[0] = '0;
    prev_data[1] = '0;

    // Reset asserted mid-cycle: outputs must settle before any clk edge.
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_ss",         32'(ss_v[0]),         32'd1);
    check("rst_async_sclk",       32'(sclk_v[0]),       32'd0);
    check("rst_async_mosi",       32'(mosi_v[0]),       32'd0);
    check("rst_async_busy",       32'(bus0.busy),       32'd0);
    check("rst_async_valid",      32'(bus0.read_valid), 32'd0);
    check("rst_async_read_data",  32'(bus0.read_data),  32'd0);
    check("rst_async_ss_pc3",     32'(ss_v[1]),         32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0 = get_rises_total(0);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_ss_idle",   32'(ss_v[0]),                    32'd1);
    check("post_rst_busy_idle", 32'(bus0.busy),                  32'd0);
    check("post_rst_no_sclk",   32'(get_rises_total(0) - r0),    32'd0);

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // run_req during the read_valid cycle starts the next frame immediately.
    miso_pat[0] = {8'h00, 8'hC3, 8'h00};
    accept(0, "chain1", 3'b000, 5'h05, 1'b0);
    wait_valid(0, 1'b0, lat);
    check("chain1_latency",   32'(lat),         32'd72);
    check("chain1_read_data", 32'(bus0.read_data), 32'hC3);
    prev_data[0] = 8'hC3;
    miso_pat[0]  = {8'h00, 8'h96, 8'h00};
    drive(0, 1'b1, 3'b000, 5'h06, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 3'b111, 5'h1F, 1'b1);
    check("chain2_valid_dropped", 32'(bus0.read_valid), 32'd0);
    check("chain2_busy",          32'(bus0.busy),       32'd1);
    check("chain2_ss_e0p1",       32'(ss_v[0]),         32'd1);
    @(posedge clk);
    #1;
    check("chain2_ss_e0p1_hold",  32'(ss_v[0]),         32'd1);
    @(posedge clk);
    #1;
    check("chain2_ss_falls_e0p2", 32'(ss_v[0]),         32'd0);
    wait_valid(0, 1'b0, lat);
    check("chain2_latency",   32'(lat),               32'd70);
    check("chain2_read_data", 32'(bus0.read_data),    32'h96);
    check("chain2_mosi_cmd",  32'(get_mosi(0) & 24'h00FFFF), 32'h0600);
    check("chain2_rises",     32'(get_rises_txn(0)),  32'd16);
    prev_data[0] = 8'h96;

    // Reset at E0+50 (data byte in progress, SCLK high) aborts the frame.
    miso_pat[0] = {8'h00, 8'h5A, 8'h00};
    accept(0, "abort", 3'b000, 5'h1D, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    check("abort_sclk_high_before_rst", 32'(sclk_v[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ss_async",    32'(ss_v[0]),         32'd1);
    check("abort_sclk_async",  32'(sclk_v[0]),       32'd0);
    check("abort_busy_async",  32'(bus0.busy),       32'd0);
    check("abort_data_zero",   32'(bus0.read_data),  32'd0);
    prev_data[0] = '0;
    prev_data[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    v0 = 0;
    r0 = get_rises_total(0);
    for (int n = 0; n < 150; n++) begin
      @(posedge clk);
      #1;
      if (bus0.read_valid) v0++;
    end
    check("abort_no_valid",      32'(v0),                        32'd0);
    check("abort_no_sclk_after", 32'(get_rises_total(0) - r0),   32'd0);
    check("abort_data_stays_0",  32'(bus0.read_data),            32'd0);
    check("abort_ss_idle",       32'(ss_v[0]),                   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound in case the DUT wedges somewhere the loops do not cover.
  initial begin
    #(CLK_PER * 20000);
    $display("FAIL watchdog: simulation exceeded %0d cycles", 20000);
    $fatal(1, "watchdog");
  end

endmodule
